// File: rtl/mux_arb_nto1.sv
// N-to-1 data selector with a one-entry registered output stage and valid/ready
// handshaking; channel chosen by explicit select or by round-robin arbitration.
module mux_arb_nto1 #(
  parameter int size     = 32,
  parameter int channels = 4,
  parameter int sel_w    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mode_i,
  input  logic [sel_w-1:0]         select_i,
  input  logic [channels*size-1:0] data_i,
  input  logic [channels-1:0]      valid_i,
  output logic [channels-1:0]      ready_o,
  output logic [size-1:0]          data_o,
  output logic                     valid_o,
  output logic [sel_w-1:0]         grant_o,
  input  logic                     ready_i
);

  logic [size-1:0]  data_q, data_d;
  logic [sel_w-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [sel_w-1:0] rrPtr_q, rrPtr_d;

  logic             rrFound;
  logic [sel_w-1:0] rrCand;
  logic             candFound;
  logic [sel_w-1:0] cand;
  logic             loadEn;
  logic [size-1:0]  selData;
  logic             transfer;

  // Round-robin search: first valid channel above the pointer, then wrap to
  // the channels at or below it.
  always_comb begin
    rrFound = 1'b0;
    rrCand  = '0;
    for (int k = 0; k < channels; k++) begin
      if (!rrFound && valid_i[k] && (k > int'(rrPtr_q))) begin
        rrFound = 1'b1;
        rrCand  = sel_w'(k);
      end
    end
    for (int k = 0; k < channels; k++) begin
      if (!rrFound && valid_i[k] && (k <= int'(rrPtr_q))) begin
        rrFound = 1'b1;
        rrCand  = sel_w'(k);
      end
    end
  end

  always_comb begin
    candFound = 1'b0;
    cand      = '0;
    if (mode_i) begin
      candFound = rrFound;
      cand      = rrCand;
    end else begin
      candFound = (int'(select_i) < channels);
      cand      = select_i;
    end
  end

  assign loadEn = !valid_q || ready_i;

  always_comb begin
    ready_o = '0;
    selData = '0;
    for (int k = 0; k < channels; k++) begin
      if (int'(cand) == k) begin
        ready_o[k] = !rst_i && candFound && loadEn;
        selData    = data_i[k*size +: size];
      end
    end
  end

  assign transfer = |(ready_o & valid_i);

  // A transfer wins over a drain, so a simultaneous drain and load keeps valid high.
  always_comb begin
    data_d  = data_q;
    grant_d = grant_q;
    valid_d = valid_q;
    rrPtr_d = rrPtr_q;
    if (transfer) begin
      data_d  = selData;
      grant_d = cand;
      valid_d = 1'b1;
      if (mode_i) begin
        rrPtr_d = cand;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      rrPtr_q <= sel_w'(channels - 1);
    end else begin
      data_q  <= data_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  assign data_o  = data_q;
  assign grant_o = grant_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Self-checking bench for mux_arb_nto1: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_mux_arb_nto1;

  localparam int SIZE = 32;
  localparam int CH   = 4;
  localparam int SEL  = 3;

  logic              clk;
  logic              rst;
  logic              mode;
  logic [SEL-1:0]    select;
  logic [CH*SIZE-1:0] dataIn;
  logic [CH-1:0]     validIn;
  logic [CH-1:0]     readyOut;
  logic [SIZE-1:0]   dataOut;
  logic              validOut;
  logic [SEL-1:0]    grantOut;
  logic              readyIn;

  int compareCount = 0;
  int failCount    = 0;

  logic            mValid = 1'b0;
  logic [SIZE-1:0] mData  = '0;
  int              mGrant = 0;
  int              mPtr   = CH - 1;

  mux_arb_nto1 #(.size(SIZE), .channels(CH), .sel_w(SEL)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .mode_i   (mode),
    .select_i (select),
    .data_i   (dataIn),
    .valid_i  (validIn),
    .ready_o  (readyOut),
    .data_o   (dataOut),
    .valid_o  (validOut),
    .grant_o  (grantOut),
    .ready_i  (readyIn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Candidate choice from the rules: direct index if in range, otherwise the
  // valid channel with the smallest circular distance after the pointer.
  task automatic modelCand(output bit found, output int c);
    int bestDist;
    found = 1'b0;
    c = 0;
    bestDist = CH + 1;
    if (!mode) begin
      found = (int'(select) < CH);
      c = int'(select);
    end else begin
      for (int k = 0; k < CH; k++) begin
        int d;
        d = (k - mPtr - 1 + 2 * CH) % CH;
        if (validIn[k] && d < bestDist) begin
          bestDist = d;
          c = k;
          found = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: check combinational ready, advance model, check registers.
  task automatic applyStimulus();
    bit found;
    int c;
    logic [CH-1:0] expReady;
    bit xfer;
    modelCand(found, c);
    expReady = '0;
    if (found && (!mValid || readyIn) && !rst) expReady[c] = 1'b1;
    #1;
    checkOutput("ready_o", 64'(readyOut), 64'(expReady));
    xfer = |(expReady & validIn);
    @(posedge clk);
    if (rst) begin
      mValid = 1'b0;
      mData  = '0;
      mGrant = 0;
      mPtr   = CH - 1;
    end else if (xfer) begin
      mData  = dataIn[c*SIZE +: SIZE];
      mGrant = c;
      mValid = 1'b1;
      if (mode) mPtr = c;
    end else if (mValid && readyIn) begin
      mValid = 1'b0;
    end
    #1;
    checkOutput("valid_o", 64'(validOut), 64'(mValid));
    checkOutput("data_o", 64'(dataOut), 64'(mData));
    checkOutput("grant_o", 64'(grantOut), 64'(mGrant));
    @(negedge clk);
  endtask

  task automatic randomData();
    for (int k = 0; k < CH; k++) dataIn[k*SIZE +: SIZE] = $urandom;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; select = '0; validIn = '1; readyIn = 1'b1;
    randomData();
    @(negedge clk);

    // Reset held with everything asserted
    applyStimulus();
    applyStimulus();
    checkOutput("reset_valid", 64'(validOut), 64'd0);
    checkOutput("reset_data", 64'(dataOut), 64'd0);

    // Round-robin rotation from channel 0
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      randomData();
      applyStimulus();
      checkOutput("rr_rotation", 64'(grantOut), 64'(i % CH));
      checkOutput("rr_valid", 64'(validOut), 64'd1);
    end
    validIn = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      randomData();
      applyStimulus();
      checkOutput("rr_alternate", 64'(grantOut), (i % 2 == 0) ? 64'd1 : 64'd3);
    end

    // Direct select, in range and out of range
    mode = 1'b0; select = 3'd2; validIn = 4'b1111;
    randomData();
    dataIn[2*SIZE +: SIZE] = 32'hCAFE0002;
    applyStimulus();
    checkOutput("direct_data", 64'(dataOut), 64'hCAFE0002);
    checkOutput("direct_grant", 64'(grantOut), 64'd2);
    select = 3'd5;
    applyStimulus();
    applyStimulus();
    checkOutput("direct_oor_drain", 64'(validOut), 64'd0);

    // Backpressure on a word from channel 1
    select = 3'd1;
    dataIn[1*SIZE +: SIZE] = 32'h1111_0001;
    applyStimulus();
    readyIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomData();
      applyStimulus();
      checkOutput("bp_hold_data", 64'(dataOut), 64'h1111_0001);
      checkOutput("bp_hold_grant", 64'(grantOut), 64'd1);
    end
    readyIn = 1'b1;
    applyStimulus();
    checkOutput("bp_reload_valid", 64'(validOut), 64'd1);

    // Mode switch keeps the round-robin pointer
    mode = 1'b1; validIn = 4'b0100;
    applyStimulus();
    checkOutput("ms_grant2", 64'(grantOut), 64'd2);
    mode = 1'b0; select = 3'd0; validIn = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      randomData();
      applyStimulus();
    end
    mode = 1'b1;
    applyStimulus();
    checkOutput("ms_next_grant", 64'(grantOut), 64'd3);

    // Reset while a word is held under backpressure
    readyIn = 1'b0;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    checkOutput("midrst_valid", 64'(validOut), 64'd0);
    checkOutput("midrst_data", 64'(dataOut), 64'd0);
    rst = 1'b0; readyIn = 1'b1;
    applyStimulus();
    checkOutput("midrst_restart", 64'(grantOut), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      mode    = 1'($urandom);
      select  = SEL'($urandom_range(0, 7));
      validIn = CH'($urandom);
      readyIn = ($urandom_range(0, 3) != 0);
      randomData();
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
